// File: rtl/sram_mrp_if.sv
// Bundles the read ports and the write port of sram_mrp.
// Pure wiring; no latency of its own.
// No backpressure: requesters drive strobes, the memory never stalls.
interface sram_mrp_if #(
  parameter int ADDR_W    = 16,
  parameter int DATA_LOG2 = 2,
  parameter int NUM_RD    = 2
);
  localparam int DW = 8 << DATA_LOG2;
  localparam int NB = 1 << DATA_LOG2;

  logic [NUM_RD-1:0]        RD_REQ;
  logic [NUM_RD*ADDR_W-1:0] RD_ADDR;
  logic [NUM_RD*DW-1:0]     RD_DATA;
  logic [NUM_RD-1:0]        RD_VALID;
  logic                     WR_REQ;
  logic [ADDR_W-1:0]        WR_ADDR;
  logic [DW-1:0]            WR_DATA;
  logic [NB-1:0]            WR_BE;
  logic                     WR_ACK;

  // Requester side
  modport master (
    output RD_REQ, RD_ADDR, WR_REQ, WR_ADDR, WR_DATA, WR_BE,
    input  RD_DATA, RD_VALID, WR_ACK
  );

  // Memory side
  modport slave (
    input  RD_REQ, RD_ADDR, WR_REQ, WR_ADDR, WR_DATA, WR_BE,
    output RD_DATA, RD_VALID, WR_ACK
  );
endinterface

// File: rtl/sram_mrp.sv
// Single-write / multi-read synchronous SRAM with byte-masked writes and per-port read pipelines.
// Read data RD_LAT cycles after the request edge; WR_ACK one cycle after an accepted write.
// No backpressure: every port takes one request per cycle, fully pipelined.
module sram_mrp #(
  parameter int ADDR_W    = 16,
  parameter int DATA_LOG2 = 2,
  parameter int NUM_RD    = 2,
  parameter int RD_LAT    = 1,
  parameter int WR_FWD    = 1
) (
  input  logic      CLK,
  input  logic      RSTn,
  sram_mrp_if.slave bus
);
  localparam int DW    = 8 << DATA_LOG2;
  localparam int NB    = 1 << DATA_LOG2;
  localparam int DEPTH = 1 << ADDR_W;

  // Storage is never reset; only the pipelines and the ack flop are.
  logic [DW-1:0] mem [DEPTH];

  logic              wr_en;
  logic [DW-1:0]     wr_mask;
  logic              wr_ack_d, wr_ack_q;
  logic [RD_LAT-1:0] vld_d [NUM_RD];
  logic [RD_LAT-1:0] vld_q [NUM_RD];
  logic [DW-1:0]     dat_d [NUM_RD][RD_LAT];
  logic [DW-1:0]     dat_q [NUM_RD][RD_LAT];
  logic [ADDR_W-1:0] rd_addr;
  logic [DW-1:0]     rd_word;

  // A write only counts when out of reset and at least one byte is enabled.
  assign wr_en    = RSTn && bus.WR_REQ && (|bus.WR_BE);
  assign wr_ack_d = wr_en;

  // Expand byte enables to a bit mask for the forwarding merge.
  always_comb begin
    wr_mask = '0;
    for (int b = 0; b < NB; b++) begin
      wr_mask[8*b +: 8] = {8{bus.WR_BE[b]}};
    end
  end

  // Byte-granular array write.
  always_ff @(posedge CLK) begin
    for (int b = 0; b < NB; b++) begin
      if (wr_en && bus.WR_BE[b]) begin
        mem[bus.WR_ADDR][8*b +: 8] <= bus.WR_DATA[8*b +: 8];
      end
    end
  end

  // Next state of each read pipeline: stage 0 samples the array (with optional
  // write forwarding), later stages shift; data regs only load on a valid so
  // the output holds its last word while idle.
  always_comb begin
    rd_addr = '0;
    rd_word = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      rd_addr = bus.RD_ADDR[p*ADDR_W +: ADDR_W];
      rd_word = mem[rd_addr];
      if ((WR_FWD != 0) && wr_en && (rd_addr == bus.WR_ADDR)) begin
        rd_word = (rd_word & ~wr_mask) | (bus.WR_DATA & wr_mask);
      end
      vld_d[p][0] = bus.RD_REQ[p];
      dat_d[p][0] = bus.RD_REQ[p] ? rd_word : dat_q[p][0];
      for (int s = 1; s < RD_LAT; s++) begin
        vld_d[p][s] = vld_q[p][s-1];
        dat_d[p][s] = vld_q[p][s-1] ? dat_q[p][s-1] : dat_q[p][s];
      end
    end
  end

  // Pipeline and ack registers; reset flushes everything in flight.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      wr_ack_q <= 1'b0;
      for (int p = 0; p < NUM_RD; p++) begin
        vld_q[p] <= '0;
        for (int s = 0; s < RD_LAT; s++) begin
          dat_q[p][s] <= '0;
        end
      end
    end else begin
      wr_ack_q <= wr_ack_d;
      for (int p = 0; p < NUM_RD; p++) begin
        vld_q[p] <= vld_d[p];
        for (int s = 0; s < RD_LAT; s++) begin
          dat_q[p][s] <= dat_d[p][s];
        end
      end
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_out
    assign bus.RD_VALID[p]         = vld_q[p][RD_LAT-1];
    assign bus.RD_DATA[p*DW +: DW] = dat_q[p][RD_LAT-1];
  end
  assign bus.WR_ACK = wr_ack_q;
endmodule

// File: tb/tb_sram_mrp.sv
// Bench for sram_mrp: four configurations driven side by side, a reference
// memory model predicts every read word and ack, and a negedge monitor pops
// the per-port scoreboards when each response is due.
module tb_sram_mrp;
  localparam int NI = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_last = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rst_last <= rst_n;

  // Drive and observe arrays, sized for the widest configuration.
  logic [3:0]  rq [NI];
  logic [15:0] ra [NI][4];
  logic        wq [NI];
  logic [15:0] wa [NI];
  logic [63:0] wd [NI];
  logic [7:0]  wb [NI];
  logic [3:0]  vo [NI];
  logic [63:0] dout [NI][4];
  logic        ack [NI];

  sram_mrp_if #(.ADDR_W(16), .DATA_LOG2(2), .NUM_RD(2)) if0 ();
  sram_mrp_if #(.ADDR_W(16), .DATA_LOG2(2), .NUM_RD(2)) if1 ();
  sram_mrp_if #(.ADDR_W(8),  .DATA_LOG2(0), .NUM_RD(1)) if2 ();
  sram_mrp_if #(.ADDR_W(10), .DATA_LOG2(3), .NUM_RD(4)) if3 ();

  sram_mrp #(.ADDR_W(16), .DATA_LOG2(2), .NUM_RD(2), .RD_LAT(3), .WR_FWD(1)) u0 (.CLK(clk), .RSTn(rst_n), .bus(if0));
  sram_mrp #(.ADDR_W(16), .DATA_LOG2(2), .NUM_RD(2), .RD_LAT(4), .WR_FWD(0)) u1 (.CLK(clk), .RSTn(rst_n), .bus(if1));
  sram_mrp #(.ADDR_W(8),  .DATA_LOG2(0), .NUM_RD(1), .RD_LAT(1), .WR_FWD(1)) u2 (.CLK(clk), .RSTn(rst_n), .bus(if2));
  sram_mrp #(.ADDR_W(10), .DATA_LOG2(3), .NUM_RD(4), .RD_LAT(2), .WR_FWD(0)) u3 (.CLK(clk), .RSTn(rst_n), .bus(if3));

  assign if0.RD_REQ  = rq[0][1:0];
  assign if0.RD_ADDR = {ra[0][1], ra[0][0]};
  assign if0.WR_REQ  = wq[0];
  assign if0.WR_ADDR = wa[0];
  assign if0.WR_DATA = wd[0][31:0];
  assign if0.WR_BE   = wb[0][3:0];
  assign if1.RD_REQ  = rq[1][1:0];
  assign if1.RD_ADDR = {ra[1][1], ra[1][0]};
  assign if1.WR_REQ  = wq[1];
  assign if1.WR_ADDR = wa[1];
  assign if1.WR_DATA = wd[1][31:0];
  assign if1.WR_BE   = wb[1][3:0];
  assign if2.RD_REQ  = rq[2][0:0];
  assign if2.RD_ADDR = ra[2][0][7:0];
  assign if2.WR_REQ  = wq[2];
  assign if2.WR_ADDR = wa[2][7:0];
  assign if2.WR_DATA = wd[2][7:0];
  assign if2.WR_BE   = wb[2][0:0];
  assign if3.RD_REQ  = rq[3];
  assign if3.RD_ADDR = {ra[3][3][9:0], ra[3][2][9:0], ra[3][1][9:0], ra[3][0][9:0]};
  assign if3.WR_REQ  = wq[3];
  assign if3.WR_ADDR = wa[3][9:0];
  assign if3.WR_DATA = wd[3];
  assign if3.WR_BE   = wb[3];

  assign vo[0] = {2'b0, if0.RD_VALID};
  assign vo[1] = {2'b0, if1.RD_VALID};
  assign vo[2] = {3'b0, if2.RD_VALID};
  assign vo[3] = if3.RD_VALID;
  assign ack[0] = if0.WR_ACK;
  assign ack[1] = if1.WR_ACK;
  assign ack[2] = if2.WR_ACK;
  assign ack[3] = if3.WR_ACK;
  assign dout[0][0] = {32'b0, if0.RD_DATA[31:0]};
  assign dout[0][1] = {32'b0, if0.RD_DATA[63:32]};
  assign dout[0][2] = 64'b0;
  assign dout[0][3] = 64'b0;
  assign dout[1][0] = {32'b0, if1.RD_DATA[31:0]};
  assign dout[1][1] = {32'b0, if1.RD_DATA[63:32]};
  assign dout[1][2] = 64'b0;
  assign dout[1][3] = 64'b0;
  assign dout[2][0] = {56'b0, if2.RD_DATA};
  assign dout[2][1] = 64'b0;
  assign dout[2][2] = 64'b0;
  assign dout[2][3] = 64'b0;
  assign dout[3][0] = if3.RD_DATA[63:0];
  assign dout[3][1] = if3.RD_DATA[127:64];
  assign dout[3][2] = if3.RD_DATA[191:128];
  assign dout[3][3] = if3.RD_DATA[255:192];

  // Per-instance configuration, mirrored from the instantiations above.
  function automatic int lat_of(int i);
    case (i) 0: return 3; 1: return 4; 2: return 1; default: return 2; endcase
  endfunction
  function automatic int fwd_of(int i);
    case (i) 0: return 1; 1: return 0; 2: return 1; default: return 0; endcase
  endfunction
  function automatic int nr_of(int i);
    case (i) 0: return 2; 1: return 2; 2: return 1; default: return 4; endcase
  endfunction
  function automatic int aw_of(int i);
    case (i) 0: return 16; 1: return 16; 2: return 8; default: return 10; endcase
  endfunction
  function automatic int nb_of(int i);
    case (i) 0: return 4; 1: return 4; 2: return 1; default: return 8; endcase
  endfunction
  function automatic logic [15:0] amask(int i);
    logic [16:0] one = 17'd1;
    logic [16:0] m   = (one << aw_of(i)) - 17'd1;
    return m[15:0];
  endfunction

  typedef struct { int due; logic [63:0] dat; } exp_t;
  exp_t        sb [NI*4][$];
  int          ack_sb [NI][$];
  logic [63:0] mdl [int];
  logic [63:0] last [NI*4];
  int          n_run = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Predict the effect of the inputs now on the bus at the coming edge, then
  // advance one cycle and return the request strobes to idle.
  task automatic tick();
    logic [63:0] m, old, nw, val;
    int key, rkey;
    bit wen;
    for (int i = 0; i < NI; i++) begin
      if (rst_n) begin
        key = i * 65536 + int'(wa[i] & amask(i));
        m = '0;
        for (int b = 0; b < nb_of(i); b++) if (wb[i][b]) m[8*b +: 8] = 8'hFF;
        wen = wq[i] && (m != 64'd0);
        old = mdl.exists(key) ? mdl[key] : 64'd0;
        nw  = (old & ~m) | (wd[i] & m);
        for (int p = 0; p < nr_of(i); p++) begin
          if (rq[i][p]) begin
            rkey = i * 65536 + int'(ra[i][p] & amask(i));
            val  = mdl.exists(rkey) ? mdl[rkey] : 64'd0;
            if (wen && rkey == key && fwd_of(i) == 1) val = nw;
            sb[i*4+p].push_back('{cyc + lat_of(i), val});
          end
        end
        if (wen) begin
          mdl[key] = nw;
          ack_sb[i].push_back(cyc + 1);
        end
      end else begin
        for (int p = 0; p < 4; p++)
          while (sb[i*4+p].size() > 0 && sb[i*4+p][$].due > cyc) void'(sb[i*4+p].pop_back());
        while (ack_sb[i].size() > 0 && ack_sb[i][$] > cyc) void'(ack_sb[i].pop_back());
      end
    end
    @(posedge clk);
    #2;
    for (int i = 0; i < NI; i++) begin
      rq[i] = '0;
      wq[i] = 1'b0;
      wb[i] = '0;
    end
  endtask

  task automatic wr(input int i, input logic [15:0] a, input logic [63:0] d, input logic [7:0] be);
    wq[i] = 1'b1; wa[i] = a; wd[i] = d; wb[i] = be;
    tick();
  endtask

  task automatic rd(input int i, input int p, input logic [15:0] a);
    rq[i][p] = 1'b1; ra[i][p] = a;
    tick();
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  // Monitor: compare each port and ack against the scoreboard when due.
  int k;
  bit ev;
  always @(negedge clk) begin
    if (cyc >= 1) begin
      for (int i = 0; i < NI; i++) begin
        for (int p = 0; p < nr_of(i); p++) begin
          k = i * 4 + p;
          if (rst_last == 1'b0) begin
            check($sformatf("rst_vld_i%0d_p%0d", i, p), {63'b0, vo[i][p]}, 64'd0);
            check($sformatf("rst_dat_i%0d_p%0d", i, p), dout[i][p], 64'd0);
            last[k] = 64'd0;
          end else begin
            ev = sb[k].size() > 0 && sb[k][0].due == cyc;
            if (ev || vo[i][p])
              check($sformatf("rd_vld_i%0d_p%0d", i, p), {63'b0, vo[i][p]}, {63'b0, ev});
            if (ev) begin
              check($sformatf("rd_dat_i%0d_p%0d", i, p), dout[i][p], sb[k][0].dat);
              last[k] = sb[k][0].dat;
              void'(sb[k].pop_front());
            end else if (!vo[i][p]) begin
              check($sformatf("rd_hold_i%0d_p%0d", i, p), dout[i][p], last[k]);
            end
          end
        end
        if (rst_last == 1'b0) begin
          check($sformatf("rst_ack_i%0d", i), {63'b0, ack[i]}, 64'd0);
        end else begin
          ev = ack_sb[i].size() > 0 && ack_sb[i][0] == cyc;
          if (ev || ack[i]) check($sformatf("wr_ack_i%0d", i), {63'b0, ack[i]}, {63'b0, ev});
          if (ev) void'(ack_sb[i].pop_front());
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      rq[i] = '0; wq[i] = 1'b0; wa[i] = '0; wd[i] = '0; wb[i] = '0;
      for (int p = 0; p < 4; p++) ra[i][p] = '0;
    end
    @(posedge clk);
    #2;
    tick();
    rst_n = 1'b1;

    // Basic write, ack and read-back.
    wr(0, 16'h0010, 64'hDEADBEEF, 8'h0F);
    rd(0, 0, 16'h0010);
    idle(4);

    // Byte masking, and a write with no enabled bytes.
    wr(0, 16'h0020, 64'h11223344, 8'h0F);
    wr(0, 16'h0020, 64'hAABBCCDD, 8'h05);
    rd(0, 1, 16'h0020);
    wr(0, 16'h0020, 64'h99999999, 8'h00);
    rd(0, 0, 16'h0020);
    idle(4);

    // Same-edge collision on both forwarding policies; both ports same address.
    for (int i = 0; i < 2; i++) begin
      wr(i, 16'h0030, 64'h0, 8'h0F);
      wq[i] = 1'b1; wa[i] = 16'h0030; wd[i] = 64'hFFFFFFFF; wb[i] = 8'h0F;
      rq[i] = 4'b0011; ra[i][0] = 16'h0030; ra[i][1] = 16'h0030;
      tick();
      rd(i, 1, 16'h0030);
    end
    // A write right after the read edge must not disturb the in-flight word.
    wr(1, 16'h0040, 64'hCAFE0001, 8'h0F);
    rd(1, 0, 16'h0040);
    wr(1, 16'h0040, 64'h12345678, 8'h0F);
    idle(6);

    // Streaming reads on both ports, opposite address order.
    for (int a = 0; a < 8; a++) wr(0, 16'(a), 64'h10203040 + 64'(a) * 64'h01010101, 8'h0F);
    for (int a = 0; a < 8; a++) begin
      rq[0] = 4'b0011; ra[0][0] = 16'(a); ra[0][1] = 16'(7 - a);
      tick();
    end
    idle(5);

    // Reset with reads in flight, plus a write that must be ignored.
    wr(1, 16'h0050, 64'hA5A5A5A5, 8'h0F);
    wr(1, 16'h0051, 64'h5A5A5A5A, 8'h0F);
    rd(1, 0, 16'h0050);
    rd(1, 1, 16'h0051);
    rst_n = 1'b0;
    wq[0] = 1'b1; wa[0] = 16'h0010; wd[0] = 64'h0BADF00D; wb[0] = 8'h0F;
    tick();
    rst_n = 1'b1;
    idle(6);
    rd(1, 0, 16'h0050);
    rd(1, 1, 16'h0051);
    rd(0, 0, 16'h0010);
    idle(6);

    // Address bounds on every configuration.
    for (int i = 0; i < NI; i++) begin
      wr(i, 16'h0000, 64'h0123456789ABCDEF ^ 64'(i), 8'hFF);
      wr(i, amask(i), 64'hFEDCBA9876543210 ^ 64'(i), 8'hFF);
      for (int p = 0; p < nr_of(i); p++) begin
        rq[i][p] = 1'b1; ra[i][p] = (p % 2 == 1) ? amask(i) : 16'h0000;
      end
      tick();
      for (int p = 0; p < nr_of(i); p++) begin
        rq[i][p] = 1'b1; ra[i][p] = (p % 2 == 1) ? 16'h0000 : amask(i);
      end
      tick();
    end
    idle(8);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
